// File: rtl/axi_llc_sram_port.sv
// axi_llc_sram_port: valid/ready request stream -> LLC SRAM req/gnt adapter.
// Read data is collected from the fixed-latency SRAM into an in-order response FIFO.
// A credit check reserves a FIFO slot for every read before it is issued, so a read
// is never lost.
// Optional ECC event counters are built when AXI_LLC_SRAM_PORT_ECC_CNT_EN is defined.
module axi_llc_sram_port #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 3,
    parameter int unsigned NumBanks  = 1,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned AddrWidth = $clog2(NumWords),
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic                 sram_gnt_i,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    input  logic [NumBanks-1:0]  single_error_i,
    input  logic [NumBanks-1:0]  multi_error_i,
    input  logic                 cnt_clr_i,
    output logic [CntWidth-1:0]  single_cnt_o,
    output logic [CntWidth-1:0]  multi_cnt_o
);

    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned OccWidth = $clog2(RspDepth + 1);
    localparam int unsigned OutWidth = $clog2(RspDepth + Latency + 1);

    logic [Latency-1:0]   pipe_q, pipe_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OccWidth-1:0]  count_q, count_d;
    logic [DataWidth-1:0] mem_q [RspDepth];
    logic [OutWidth-1:0]  outstanding;
    logic                 credit_ok, rd_hs, push, pop, empty;

    // Reads owed a FIFO slot: in the latency pipe plus already stored (registered state only).
    always_comb begin
        outstanding = OutWidth'(count_q);
        for (int unsigned i = 0; i < Latency; i++) begin
            outstanding = outstanding + OutWidth'(pipe_q[i]);
        end
    end

    assign credit_ok    = req_we_i | (outstanding < OutWidth'(RspDepth));
    assign sram_req_o   = req_valid_i & credit_ok;
    assign req_ready_o  = sram_gnt_i & credit_ok;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign rd_hs       = req_valid_i & req_ready_o & ~req_we_i;
    assign push        = pipe_q[Latency-1];
    assign empty       = (count_q == '0);
    assign pop         = ~empty & rsp_ready_i;
    assign rsp_valid_o = ~empty;
    assign rsp_rdata_o = empty ? '0 : mem_q[rd_ptr_q];

    // Next state of the latency pipe, FIFO pointers and occupancy.
    always_comb begin
        // Shift left by one; the oldest bit drops off the top.
        pipe_d   = Latency'({pipe_q, rd_hs});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
        count_d = count_q + OccWidth'(push) - OccWidth'(pop);
    end

    // Control state register; reset discards in-flight reads and stored responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only visible while occupied, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sram_rdata_i;
        end
    end

`ifdef AXI_LLC_SRAM_PORT_ECC_CNT_EN
    logic [CntWidth-1:0] single_cnt_q, single_cnt_d, multi_cnt_q, multi_cnt_d;

    // Saturating event counters; clear wins over an increment.
    always_comb begin
        single_cnt_d = single_cnt_q;
        multi_cnt_d  = multi_cnt_q;
        if (cnt_clr_i) begin
            single_cnt_d = '0;
            multi_cnt_d  = '0;
        end else begin
            if ((|single_error_i) && !(&single_cnt_q)) single_cnt_d = single_cnt_q + 1'b1;
            if ((|multi_error_i) && !(&multi_cnt_q)) multi_cnt_d = multi_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            single_cnt_q <= '0;
            multi_cnt_q  <= '0;
        end else begin
            single_cnt_q <= single_cnt_d;
            multi_cnt_q  <= multi_cnt_d;
        end
    end

    assign single_cnt_o = single_cnt_q;
    assign multi_cnt_o  = multi_cnt_q;
`else
    logic unused_ecc;
    assign unused_ecc   = ^{single_error_i, multi_error_i, cnt_clr_i};
    assign single_cnt_o = '0;
    assign multi_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_axi_llc_sram_port.sv
// Directed bench for axi_llc_sram_port (Latency=1, RspDepth=3, CntWidth=8).
module tb_axi_llc_sram_port;
    localparam int unsigned DW  = 128;
    localparam int unsigned AW  = 10;
    localparam int unsigned BEW = 16;
    localparam int unsigned CW  = 8;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic [BEW-1:0] req_be = '1;
    logic           req_ready, sram_req, sram_we, sram_gnt = 1'b1;
    logic [AW-1:0]  sram_addr;
    logic [DW-1:0]  sram_wdata, sram_rdata;
    logic [BEW-1:0] sram_be;
    logic           rsp_valid, rsp_ready = 1'b1;
    logic [DW-1:0]  rsp_rdata;
    logic [0:0]     single_err = '0, multi_err = '0;
    logic           cnt_clr = 1'b0;
    logic [CW-1:0]  single_cnt, multi_cnt;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] rsp_q[$];
    int acc;

    always #5 clk = ~clk;

    axi_llc_sram_port #(
        .NumWords(1024), .DataWidth(DW), .ByteWidth(8), .Latency(1), .RspDepth(3),
        .NumBanks(1), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_gnt_i(sram_gnt),
        .sram_rdata_i(sram_rdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .single_error_i(single_err), .multi_error_i(multi_err), .cnt_clr_i(cnt_clr),
        .single_cnt_o(single_cnt), .multi_cnt_o(multi_cnt)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 + a;
        return {4{w}};
    endfunction

    // SRAM model, 1-cycle read latency; unwritten words return init_word(addr).
    logic [DW-1:0] smem [1024];
    logic          written [1024];
    logic [DW-1:0] rdata_q = '0;
    assign sram_rdata = rdata_q;
    always @(posedge clk) begin
        if (sram_req && sram_gnt) begin
            if (sram_we) begin
                for (int b = 0; b < 16; b++) begin
                    if (sram_be[b]) smem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
                written[sram_addr] <= 1'b1;
            end else begin
                rdata_q <= (written[sram_addr] === 1'b1) ? smem[sram_addr]
                                                         : init_word(int'(sram_addr));
            end
        end
    end

    // Response monitor and FIFO overflow check.
    always @(negedge clk) begin
        if (rst_ni && rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
        if (rst_ni && dut.push && !dut.pop && int'(dut.count_q) == 3) begin
            errors++;
            $error("FAIL fifo_overflow: push into full FIFO, count=%0d required<3",
                   int'(dut.count_q));
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick; tick; mid;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_ready_eq_gnt", 128'(req_ready), 128'(1));
        chk("rst_sram_req", 128'(sram_req), 128'(0));
        chk("rst_single_cnt", 128'(single_cnt), 128'(0));
        chk("rst_multi_cnt", 128'(multi_cnt), 128'(0));
        rst_ni = 1'b1;

        // Write A5.. to addr 5, read it back
        tick; req_valid = 1; req_we = 1; req_addr = 5; req_wdata = {16{8'hA5}};
        mid; chk("wr_ready", 128'(req_ready), 128'(1));
        tick; req_we = 0; req_wdata = '0;
        mid; chk("rd_ready", 128'(req_ready), 128'(1));
        chk("rd_sram_req", 128'(sram_req), 128'(1));
        tick; req_valid = 0;
        mid; chk("rd_valid_t1", 128'(rsp_valid), 128'(0));
        tick; mid;
        chk("rd_valid_t2", 128'(rsp_valid), 128'(1));
        chk("rd_data_t2", rsp_rdata, {16{8'hA5}});
        tick; mid; chk("rd_valid_t3", 128'(rsp_valid), 128'(0));
        rsp_q.delete();

        // 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            tick; req_valid = 1; req_we = 0; req_addr = AW'(16 + i);
            mid; chk($sformatf("b2b_ready_%0d", i), 128'(req_ready), 128'(1));
        end
        tick; req_valid = 0;
        repeat (6) tick;
        mid;
        chk("b2b_count", 128'(rsp_q.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            if (rsp_q.size() > i) chk($sformatf("b2b_data_%0d", i), rsp_q[i], init_word(16 + i));
        end
        rsp_q.delete();

        // Backpressure: 5 reads offered, only 3 fit
        rsp_ready = 0; acc = 0;
        for (int c = 0; c < 8; c++) begin
            tick; req_valid = 1; req_we = 0; req_addr = AW'(32 + acc);
            mid; if (req_ready) acc++;
        end
        chk("stall_accepted", 128'(acc), 128'(3));
        chk("stall_ready", 128'(req_ready), 128'(0));
        chk("stall_rsp_valid", 128'(rsp_valid), 128'(1));
        tick; req_we = 1; req_addr = 40; req_wdata = {16{8'h5A}};
        mid; chk("stall_wr_ready", 128'(req_ready), 128'(1));
        for (int c = 0; c < 20; c++) begin
            tick; req_valid = (acc < 5); req_we = 0; req_addr = AW'(32 + acc); rsp_ready = 1;
            mid; if (req_valid && req_ready) acc++;
        end
        chk("stall_total", 128'(acc), 128'(5));
        chk("stall_rsp_count", 128'(rsp_q.size()), 128'(5));
        for (int i = 0; i < 5; i++) begin
            if (rsp_q.size() > i) chk($sformatf("stall_data_%0d", i), rsp_q[i], init_word(32 + i));
        end
        rsp_q.delete();

        // Grant withheld for 4 cycles; read of the word written during the stall
        sram_gnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick; req_valid = 1; req_we = 0; req_addr = 40;
            mid;
            chk("nognt_sram_req", 128'(sram_req), 128'(1));
            chk("nognt_ready", 128'(req_ready), 128'(0));
            chk("nognt_rsp_valid", 128'(rsp_valid), 128'(0));
        end
        tick; sram_gnt = 1;
        mid; chk("gnt_ready", 128'(req_ready), 128'(1));
        tick; req_valid = 0;
        repeat (4) tick;
        mid;
        chk("gnt_rsp_count", 128'(rsp_q.size()), 128'(1));
        if (rsp_q.size() > 0) chk("gnt_rsp_data", rsp_q[0], {16{8'h5A}});
        rsp_q.delete();

        // Reset with two reads in flight
        rsp_ready = 0;
        tick; req_valid = 1; req_addr = 60;
        mid; chk("rstmid_ready0", 128'(req_ready), 128'(1));
        tick; req_addr = 61;
        mid; chk("rstmid_ready1", 128'(req_ready), 128'(1));
        tick; req_valid = 0; rst_ni = 0;
        mid;
        chk("rstmid_valid", 128'(rsp_valid), 128'(0));
        chk("rstmid_rdata", rsp_rdata, '0);
        tick; mid; chk("rstmid_valid2", 128'(rsp_valid), 128'(0));
        rst_ni = 1; rsp_ready = 1;
        repeat (6) tick;
        mid;
        chk("rstmid_no_rsp", 128'(rsp_q.size()), 128'(0));
        chk("rstmid_valid_after", 128'(rsp_valid), 128'(0));

`ifdef AXI_LLC_SRAM_PORT_ECC_CNT_EN
        for (int k = 0; k < 3; k++) begin
            tick; single_err = 1;
            tick; single_err = 0;
        end
        mid;
        chk("ecc_single3", 128'(single_cnt), 128'(3));
        chk("ecc_multi0", 128'(multi_cnt), 128'(0));
        tick; multi_err = 1;
        tick; multi_err = 0;
        mid; chk("ecc_multi1", 128'(multi_cnt), 128'(1));
        tick; single_err = 1; cnt_clr = 1;
        tick; single_err = 0; cnt_clr = 0;
        mid;
        chk("ecc_clr_single", 128'(single_cnt), 128'(0));
        chk("ecc_clr_multi", 128'(multi_cnt), 128'(0));
        tick; single_err = 1;
        repeat (255) tick;
        mid; chk("ecc_full", 128'(single_cnt), 128'(255));
        tick;
        mid; chk("ecc_saturate", 128'(single_cnt), 128'(255));
        single_err = 0;
`else
        tick; single_err = 1; multi_err = 1; cnt_clr = 0;
        tick; tick; single_err = 0; multi_err = 0;
        mid;
        chk("ecc_off_single", 128'(single_cnt), 128'(0));
        chk("ecc_off_multi", 128'(multi_cnt), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
